// File: rtl/air_hockey_renderer_if.sv
// Signal bundle between the VGA timing/game-logic side and the air hockey pixel renderer.
interface air_hockey_renderer_if;
  logic [9:0] counter_x;
  logic [9:0] counter_y;
  logic       hsync_in;
  logic       vsync_in;
  logic [9:0] puck_x;
  logic [9:0] puck_y;
  logic [9:0] pad1_x;
  logic [9:0] pad1_y;
  logic [9:0] pad2_x;
  logic [9:0] pad2_y;
  logic       goal_pulse;
  logic       vgaRed;
  logic       vgaGreen;
  logic       vgaBlue;
  logic       Hsync;
  logic       Vsync;
  logic       frame_start;

  modport master (
    output counter_x, counter_y, hsync_in, vsync_in,
    output puck_x, puck_y, pad1_x, pad1_y, pad2_x, pad2_y, goal_pulse,
    input  vgaRed, vgaGreen, vgaBlue, Hsync, Vsync, frame_start
  );

  modport slave (
    input  counter_x, counter_y, hsync_in, vsync_in,
    input  puck_x, puck_y, pad1_x, pad1_y, pad2_x, pad2_y, goal_pulse,
    output vgaRed, vgaGreen, vgaBlue, Hsync, Vsync, frame_start
  );
endinterface

// File: rtl/air_hockey_renderer.sv
// Two-stage pixel pipeline: per-frame shadowed object positions, hit tests, priority colour mux
// and a goal-flash counter that turns the field border red.
module air_hockey_renderer #(
  parameter int unsigned FIELD_X0     = 128,
  parameter int unsigned FIELD_X1     = 751,
  parameter int unsigned FIELD_Y0     = 16,
  parameter int unsigned FIELD_Y1     = 495,
  parameter int unsigned BORDER_W     = 4,
  parameter int unsigned PUCK_SIZE    = 8,
  parameter int unsigned PAD_W        = 8,
  parameter int unsigned PAD_H        = 48,
  parameter int unsigned FLASH_FRAMES = 60
) (
  input logic                  clk,
  input logic                  rst_n,
  air_hockey_renderer_if.slave bus
);
  localparam logic [10:0] X0    = 11'(FIELD_X0);
  localparam logic [10:0] X1    = 11'(FIELD_X1);
  localparam logic [10:0] Y0    = 11'(FIELD_Y0);
  localparam logic [10:0] Y1    = 11'(FIELD_Y1);
  localparam logic [10:0] BW    = 11'(BORDER_W);
  localparam logic [10:0] PS    = 11'(PUCK_SIZE);
  localparam logic [10:0] PW    = 11'(PAD_W);
  localparam logic [10:0] PH    = 11'(PAD_H);
  localparam logic [10:0] MID   = 11'((FIELD_X0 + FIELD_X1) >> 1);
  localparam logic [7:0]  FLASH = 8'(FLASH_FRAMES);

  // Frame boundary detection and shadowed positions
  logic       vs_d_q, armed_q, frame_start_q, fs_det;
  logic [9:0] puck_x_q, puck_y_q, pad1_x_q, pad1_y_q, pad2_x_q, pad2_y_q;
  logic [7:0] flash_q, flash_d;

  // armed_q suppresses a spurious edge when vsync_in is already low as reset releases
  assign fs_det = vs_d_q & ~bus.vsync_in & armed_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_d_q        <= 1'b1;
      armed_q       <= 1'b0;
      frame_start_q <= 1'b0;
      puck_x_q      <= '0;
      puck_y_q      <= '0;
      pad1_x_q      <= '0;
      pad1_y_q      <= '0;
      pad2_x_q      <= '0;
      pad2_y_q      <= '0;
      flash_q       <= '0;
    end else begin
      vs_d_q        <= bus.vsync_in;
      armed_q       <= 1'b1;
      frame_start_q <= fs_det;
      flash_q       <= flash_d;
      if (fs_det) begin
        puck_x_q <= bus.puck_x;
        puck_y_q <= bus.puck_y;
        pad1_x_q <= bus.pad1_x;
        pad1_y_q <= bus.pad1_y;
        pad2_x_q <= bus.pad2_x;
        pad2_y_q <= bus.pad2_y;
      end
    end
  end

  always_comb begin
    flash_d = flash_q;
    if (bus.goal_pulse) begin
      flash_d = FLASH;
    end else if (fs_det && (flash_q != '0)) begin
      flash_d = flash_q - 8'd1;
    end
  end

  // Stage 1: hit tests on 11-bit operands so ox+SIZE cannot wrap
  function automatic logic obj_hit(input logic [10:0] px, input logic [10:0] py,
                                   input logic [9:0] ox, input logic [9:0] oy,
                                   input logic [10:0] w, input logic [10:0] h);
    logic [10:0] x0, y0;
    x0 = {1'b0, ox};
    y0 = {1'b0, oy};
    return (px >= x0) && (px < x0 + w) && (py >= y0) && (py < y0 + h);
  endfunction

  logic [10:0] x, y;
  logic        in_field, near_edge;
  logic        puck_s1_d, pad1_s1_d, pad2_s1_d, border_s1_d, center_s1_d;
  logic        puck_s1_q, pad1_s1_q, pad2_s1_q, border_s1_q, center_s1_q;
  logic        hs_s1_q, vs_s1_q;

  assign x = {1'b0, bus.counter_x};
  assign y = {1'b0, bus.counter_y};

  always_comb begin
    in_field    = (x >= X0) && (x <= X1) && (y >= Y0) && (y <= Y1);
    near_edge   = (x < X0 + BW) || (x > X1 - BW) || (y < Y0 + BW) || (y > Y1 - BW);
    puck_s1_d   = in_field && obj_hit(x, y, puck_x_q, puck_y_q, PS, PS);
    pad1_s1_d   = in_field && obj_hit(x, y, pad1_x_q, pad1_y_q, PW, PH);
    pad2_s1_d   = in_field && obj_hit(x, y, pad2_x_q, pad2_y_q, PW, PH);
    border_s1_d = in_field && near_edge;
    center_s1_d = in_field && !near_edge && ((x == MID) || (x == MID + 11'd1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      puck_s1_q   <= 1'b0;
      pad1_s1_q   <= 1'b0;
      pad2_s1_q   <= 1'b0;
      border_s1_q <= 1'b0;
      center_s1_q <= 1'b0;
      hs_s1_q     <= 1'b1;
      vs_s1_q     <= 1'b1;
    end else begin
      puck_s1_q   <= puck_s1_d;
      pad1_s1_q   <= pad1_s1_d;
      pad2_s1_q   <= pad2_s1_d;
      border_s1_q <= border_s1_d;
      center_s1_q <= center_s1_d;
      hs_s1_q     <= bus.hsync_in;
      vs_s1_q     <= bus.vsync_in;
    end
  end

  // Stage 2: priority colour mux
  logic [2:0] rgb_d, rgb_q;
  logic       hs_s2_q, vs_s2_q;

  always_comb begin
    rgb_d = 3'b000;
    if (puck_s1_q) begin
      rgb_d = 3'b111;
    end else if (pad1_s1_q) begin
      rgb_d = 3'b100;
    end else if (pad2_s1_q) begin
      rgb_d = 3'b010;
    end else if (border_s1_q) begin
      rgb_d = (flash_q != '0) ? 3'b100 : 3'b111;
    end else if (center_s1_q) begin
      rgb_d = 3'b001;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_q   <= '0;
      hs_s2_q <= 1'b1;
      vs_s2_q <= 1'b1;
    end else begin
      rgb_q   <= rgb_d;
      hs_s2_q <= hs_s1_q;
      vs_s2_q <= vs_s1_q;
    end
  end

  assign bus.vgaRed      = rgb_q[2];
  assign bus.vgaGreen    = rgb_q[1];
  assign bus.vgaBlue     = rgb_q[0];
  assign bus.Hsync       = hs_s2_q;
  assign bus.Vsync       = vs_s2_q;
  assign bus.frame_start = frame_start_q;
endmodule
